// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the N-channel RAM arbiter:
//   - arb_state_t   : arbiter FSM state (ARB_IDLE / ARB_BUSY)
//   - DEF_ADDR_W    : default RAM address width
//   - DEF_DATA_W    : default RAM data width
//   - onehot_to_idx : converts a one-hot vector (up to 8 bits) to its index
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 10;

    // OR-reduction of the indices of set bits; exact for a one-hot input,
    // 0 for an all-zero input.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ram_arbiter_n_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational winner selection for the RAM arbiter. The candidate set
// (i_req & i_mask) is rotated so that channel i_ptr sits at bit 0, the lowest
// set bit is isolated, and the result is rotated back. With i_ptr = 0 this
// is plain fixed priority (lowest index wins).
// Ports:
//   i_req   [N_CH]  current requests
//   i_mask  [N_CH]  channels allowed to compete
//   i_ptr   [PW]    channel with highest priority this cycle (< N_CH)
//   o_grant [N_CH]  one-hot winner (all zero when nobody competes)
//   o_valid         at least one channel competes
// ---------------------------------------------------------------------------
module arb_pick
    import ram_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int PW   = 2
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [N_CH-1:0] i_mask,
    input  logic [PW-1:0]   i_ptr,
    output logic [N_CH-1:0] o_grant,
    output logic            o_valid
);

    logic [N_CH-1:0] w_cand;
    logic [N_CH-1:0] w_rot;
    logic [N_CH-1:0] w_low;

    always_comb begin
        w_cand  = i_req & i_mask;
        w_rot   = '0;
        o_grant = '0;
        // rotate right by i_ptr
        for (int i = 0; i < N_CH; i++) begin
            w_rot[i] = w_cand[(i + int'(i_ptr)) % N_CH];
        end
        // isolate lowest set bit
        w_low = w_rot & (~w_rot + 1'b1);
        // rotate back left by i_ptr
        for (int i = 0; i < N_CH; i++) begin
            o_grant[(i + int'(i_ptr)) % N_CH] = w_low[i];
        end
        o_valid = |w_cand;
    end

endmodule

// File: rtl/ram_arbiter_n.sv
// ---------------------------------------------------------------------------
// ram_arbiter_n
// N-channel arbiter and multiplexer in front of a single-port synchronous
// RAM. Owners hold the RAM for bursts of at most MAX_BURST beats; handovers
// happen on the same edge as the release, so back-to-back requesters see one
// access per cycle. Reads are returned one cycle later, tagged with rvalid.
//
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) and the round-robin pointer
// stays at 0.
//
// Handshake: grant is a registered one-hot owner. An access is performed in
// every cycle where grant[k] & req[k]; the channel then advances its
// addr/wdata/we for the following cycle. Dropping req[k] while granted
// releases ownership at the next edge.
//
// Ports:
//   clk, rst (sync, active-low)
//   req/we [N_CH], addr [N_CH*ADDR_W], wdata [N_CH*DATA_W]  channel side
//   grant/rvalid [N_CH], rdata [DATA_W]                        channel side
//   ram_addr, ram_read, ram_write, ram_wdata, ram_rdata        RAM side
//   D_STATE, D_OWNER, D_BEATS, D_PRIORITY                      debug
// ---------------------------------------------------------------------------
module ram_arbiter_n
    import ram_arb_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   wdata,
    output logic [N_CH-1:0]          grant,
    output logic [N_CH-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_read,
    output logic                     ram_write,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic                     D_STATE,
    output logic [2:0]               D_OWNER,
    output logic [7:0]               D_BEATS,
    output logic [2:0]               D_PRIORITY
);

    localparam int              OW        = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [7:0]      LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [N_CH-1:0] ONE_HOT0  = {{(N_CH-1){1'b0}}, 1'b1};

    arb_state_t      r_state,  w_state_nxt;
    logic [OW-1:0]   r_owner,  w_owner_nxt;
    logic [OW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [N_CH-1:0] r_grant,  w_grant_nxt;
    logic [N_CH-1:0] r_rvalid, w_rvalid_nxt;
    logic [7:0]      r_beats,  w_beats_nxt;

    logic [N_CH-1:0] w_mask;
    logic [N_CH-1:0] w_pick_oh;
    logic            w_pick_valid;
    logic [OW-1:0]   w_pick_idx;
    logic [OW-1:0]   w_ptr;
    logic            w_owner_req;
    logic            w_owner_we;
    logic            w_access;

    assign w_owner_req = req[r_owner];
    assign w_owner_we  = we[r_owner];
    assign w_access    = (r_state == ARB_BUSY) && w_owner_req;

    // Everyone competes at a release edge; an owner that dropped its request
    // is explicitly kept out even though its req bit is already low.
    always_comb begin
        w_mask = '1;
        if (r_state == ARB_BUSY && !w_owner_req) begin
            w_mask[r_owner] = 1'b0;
        end
    end

`ifdef RAM_ARB_ROUND_ROBIN_EN
    assign w_ptr = r_rr_ptr;
`else
    assign w_ptr = '0;
`endif

    arb_pick #(
        .N_CH (N_CH),
        .PW   (OW)
    ) u_pick (
        .i_req   (req),
        .i_mask  (w_mask),
        .i_ptr   (w_ptr),
        .o_grant (w_pick_oh),
        .o_valid (w_pick_valid)
    );

    assign w_pick_idx = OW'(onehot_to_idx(8'(w_pick_oh)));

    // Next-state: hold the owner while it requests and the burst is not
    // exhausted, otherwise hand over in the same edge (or go idle).
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_grant_nxt  = r_grant;
        w_beats_nxt  = r_beats;
        w_rr_ptr_nxt = r_rr_ptr;

        if (r_state == ARB_BUSY && w_owner_req && r_beats < LAST_BEAT) begin
            w_beats_nxt = r_beats + 8'd1;
        end else if (w_pick_valid) begin
            w_state_nxt = ARB_BUSY;
            w_owner_nxt = w_pick_idx;
            w_grant_nxt = w_pick_oh;
            w_beats_nxt = 8'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            w_rr_ptr_nxt = (w_pick_idx == OW'(N_CH - 1)) ? '0 : w_pick_idx + 1'b1;
`endif
        end else begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = '0;
            w_beats_nxt = 8'd0;
        end

        // rd_pend: a read issued now returns next cycle for this owner
        w_rvalid_nxt = (w_access && !w_owner_we) ? (ONE_HOT0 << r_owner) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_grant  <= '0;
            r_beats  <= 8'd0;
            r_rr_ptr <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_grant  <= w_grant_nxt;
            r_beats  <= w_beats_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_rvalid <= w_rvalid_nxt;
        end
    end

    // RAM side is driven combinationally from the owner; quiet when no access.
    assign ram_addr  = w_access ? addr[int'(r_owner)*ADDR_W +: ADDR_W]  : '0;
    assign ram_wdata = w_access ? wdata[int'(r_owner)*DATA_W +: DATA_W] : '0;
    assign ram_read  = w_access & ~w_owner_we;
    assign ram_write = w_access &  w_owner_we;

    // Read data is broadcast; rvalid identifies the channel it belongs to.
    assign rdata  = ram_rdata;
    assign grant  = r_grant;
    assign rvalid = r_rvalid;

    assign D_STATE    = (r_state == ARB_BUSY);
    assign D_OWNER    = 3'(r_owner);
    assign D_BEATS    = r_beats;
    assign D_PRIORITY = 3'(r_rr_ptr);

endmodule

// File: tb/tb_ram_arbiter_n.sv
module tb_ram_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 10;
    localparam int MB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req, we, grant, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
    logic [AW-1:0]   ram_addr;
    logic            ram_read, ram_write, D_STATE;
    logic [2:0]      D_OWNER, D_PRIORITY;
    logic [7:0]      D_BEATS;

    ram_arbiter_n #(
        .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .grant(grant), .rvalid(rvalid), .rdata(rdata),
        .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .D_STATE(D_STATE), .D_OWNER(D_OWNER), .D_BEATS(D_BEATS),
        .D_PRIORITY(D_PRIORITY)
    );

    // ---------------- RAM model ----------------
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] sh_mem  [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_wdata;
        if (ram_read)  ram_rdata <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters / check ----------------
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- per-channel beat lists ----------------
    logic          ch_we   [N][64];
    logic [AW-1:0] ch_addr [N][64];
    logic [DW-1:0] ch_wd   [N][64];
    int            ch_len  [N];
    int            ch_pos  [N];
    bit            gaps;

    task automatic add_beat(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (ch_pos[k] == ch_len[k]) begin
            ch_pos[k] = 0;
            ch_len[k] = 0;
        end
        ch_we[k][ch_len[k]]   = w;
        ch_addr[k][ch_len[k]] = a;
        ch_wd[k][ch_len[k]]   = d;
        ch_len[k]++;
    endtask

    function automatic bit all_done();
        for (int k = 0; k < N; k++) if (ch_pos[k] < ch_len[k]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- reference model (rule level) ----------------
    bit m_busy;
    int m_owner, m_cnt, m_ptr;

    function automatic int pick(input logic [N-1:0] r);
        for (int j = 0; j < N; j++) begin
            int c;
            c = (m_ptr + j) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rst_v);
        int w;
        if (!rst_v) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else if (m_busy && r[m_owner] && m_cnt < MB - 1) begin
            m_cnt++;
        end else begin
            w = pick(r);
            if (w < 0) begin
                m_busy = 0;
            end else begin
                m_busy = 1; m_owner = w; m_cnt = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                m_ptr = (w + 1) % N;
`endif
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DW+1:0] exp_q[$];      // {channel, data}
    int            exp_cyc_q[$];  // cycle of the read access

    always @(posedge clk) begin
        #3;
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc - 1) begin
            chk("rvalid", 32'(rvalid), 32'(1) << exp_q[0][DW+1:DW]);
            chk("rdata", 32'(rdata), 32'(exp_q[0][DW-1:0]));
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end else begin
            chk("rvalid_quiet", 32'(rvalid), 32'd0);
        end
    end

    // ---------------- driver ----------------
    bit           log_en;
    logic [N-1:0] g_log [0:127];
    int           g_n;

    task automatic run_cycle(input logic rst_v);
        logic [N-1:0] r;
        int o, p;
        #1;
        rst = rst_v;
        for (int k = 0; k < N; k++) begin
            if (ch_pos[k] < ch_len[k]) begin
                r[k] = gaps ? ($urandom_range(3) != 0) : 1'b1;
                we[k] = ch_we[k][ch_pos[k]];
                addr[k*AW +: AW]  = ch_addr[k][ch_pos[k]];
                wdata[k*DW +: DW] = ch_wd[k][ch_pos[k]];
            end else begin
                r[k] = 1'b0;
                we[k] = 1'b0;
                addr[k*AW +: AW]  = '0;
                wdata[k*DW +: DW] = '0;
            end
        end
        req = r;
        #1;
        chk("grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("d_state", 32'(D_STATE), 32'(m_busy));
        chk("d_priority", 32'(D_PRIORITY), 32'(m_ptr));
        if (m_busy) begin
            chk("d_owner", 32'(D_OWNER), 32'(m_owner));
            chk("d_beats", 32'(D_BEATS), 32'(m_cnt));
        end
        if (log_en && g_n < 128) begin
            g_log[g_n] = grant;
            g_n++;
        end
        if (m_busy && r[m_owner]) begin
            o = m_owner;
            p = ch_pos[o];
            chk("ram_read", 32'(ram_read), 32'(!ch_we[o][p]));
            chk("ram_write", 32'(ram_write), 32'(ch_we[o][p]));
            chk("ram_addr", 32'(ram_addr), 32'(ch_addr[o][p]));
            if (ch_we[o][p]) begin
                chk("ram_wdata", 32'(ram_wdata), 32'(ch_wd[o][p]));
                sh_mem[ch_addr[o][p]] = ch_wd[o][p];
            end else if (rst_v) begin
                exp_q.push_back({2'(o), sh_mem[ch_addr[o][p]]});
                exp_cyc_q.push_back(cyc);
            end
            ch_pos[o]++;
        end else begin
            chk("ram_strobes", 32'({ram_read, ram_write}), 32'd0);
            if (!m_busy) chk("idle_bus", 32'({ram_addr, ram_wdata}), 32'd0);
        end
        model_step(r, rst_v);
        @(posedge clk);
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && !all_done(); i++) run_cycle(1'b1);
        chk("scenario_done", 32'(all_done()), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = DW'($urandom);
            sh_mem[i]  = ram_mem[i];
        end
        for (int k = 0; k < N; k++) begin
            ch_len[k] = 0;
            ch_pos[k] = 0;
        end
        gaps = 0; log_en = 0; g_n = 0;
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        @(posedge clk);

        // reset held with all channels requesting
        for (int k = 0; k < N; k++) add_beat(k, 1'b0, AW'($urandom_range(63)), '0);
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_until_done(50);
        run_cycle(1'b1);

        // single read on channel 2
        add_beat(2, 1'b0, 14'h0123, '0);
        run_until_done(20);
        run_cycle(1'b1);

        // burst limit: ch0 long, ch1 shorter
        for (int j = 0; j < 8; j++) add_beat(0, 1'($urandom_range(1)), AW'($urandom_range(63)), DW'($urandom));
        for (int j = 0; j < 4; j++) add_beat(1, 1'($urandom_range(1)), AW'($urandom_range(63)), DW'($urandom));
        run_until_done(60);
        run_cycle(1'b1);

        // all four requesting continuously from a fresh pointer
        run_cycle(1'b0);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 20; j++) add_beat(k, 1'b0, AW'($urandom_range(63)), '0);
        log_en = 1; g_n = 0;
        run_until_done(120);
        log_en = 0;
        for (int i = 0; i < 17; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            chk("rr_order", 32'(g_log[i+1]), 32'd1 << ((i / MB) % N));
`else
            chk("fixed_order", 32'(g_log[i+1]), 32'd1);
`endif
        end
        run_cycle(1'b1);

        // ch3 writes, then ch1 reads the same word
        add_beat(3, 1'b1, 14'd5, 10'h2AA);
        run_until_done(20);
        add_beat(1, 1'b0, 14'd5, '0);
        run_until_done(20);
        run_cycle(1'b1);

        // reset during beat 2 of a ch1 read burst
        for (int j = 0; j < 4; j++) add_beat(1, 1'b0, AW'($urandom_range(63)), '0);
        run_cycle(1'b1);   // request, grant on next edge
        run_cycle(1'b1);   // beat 0
        run_cycle(1'b1);   // beat 1
        run_cycle(1'b0);   // beat 2 under reset: its read is dropped
        run_until_done(40);
        run_cycle(1'b1);

        // randomized traffic with request gaps
        gaps = 1;
        for (int round = 0; round < 25; round++) begin
            for (int k = 0; k < N; k++) begin
                int n;
                n = $urandom_range(6);
                for (int j = 0; j < n; j++)
                    add_beat(k, 1'($urandom_range(1)), AW'($urandom_range(63)), DW'($urandom));
            end
            run_until_done(400);
        end
        gaps = 0;

        for (int i = 0; i < 3; i++) run_cycle(1'b1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
